// File: rtl/block_output_deinterleaver_pkg.sv
// Shared types for the block output deinterleaver: read-side FSM states and
// the block/symbol to linear bank address mapping.
package block_output_deinterleaver_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BURST,
    RD_GAP
  } rd_state_e;

  // Bank layout is block-major: all N symbols of block 0, then block 1, ...
  function automatic int unsigned lin_addr(input int unsigned blk,
                                           input int unsigned sym,
                                           input int unsigned n);
    return blk * n + sym;
  endfunction

endpackage

// File: rtl/block_output_deinterleaver_bank.sv
// One ping-pong bank: DEPTH entries of V words, registered single-port write,
// combinational single-port read.
module block_output_deinterleaver_bank
  import block_output_deinterleaver_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int V     = 4,
  parameter int DEPTH = 40,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [BITS-1:0] i_wdata [V],
  input  logic [AW-1:0]   i_raddr,
  output logic [BITS-1:0] o_rdata [V]
);

  logic [BITS-1:0] r_mem [DEPTH][V];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned j = 0; j < V; j++) begin
        r_mem[i_waddr][j] <= i_wdata[j];
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < V; j++) begin
      o_rdata[j] = r_mem[i_raddr][j];
    end
  end

endmodule

// File: rtl/block_output_deinterleaver.sv
// Reorders a round-robin interleaved stream of IIR blocks into block-contiguous
// bursts using two ping-pong banks; one idle cycle separates every block burst.
module block_output_deinterleaver
  import block_output_deinterleaver_pkg::*;
#(
  parameter int BITS = 32,
  parameter int IIR  = 2,
  parameter int N    = 20,
  parameter int V    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] data_in  [V],
  output logic            out_valid,
  output logic [BITS-1:0] data_out [V],
  output logic            overflow
);

  localparam int DEPTH = IIR * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (IIR > 1) ? $clog2(IIR) : 1;
  localparam int SW    = $clog2(N);
  localparam logic [BW-1:0] LAST_B = BW'(IIR - 1);
  localparam logic [SW-1:0] LAST_S = SW'(N - 1);

  // write side
  logic          r_wbank;
  logic [BW-1:0] r_wb;
  logic [SW-1:0] r_ws;
  logic [1:0]    r_full;
  logic          r_overflow;
  logic          w_release;
  logic          w_wr_blocked;
  logic          w_wr_en;
  logic          w_wr_last;
  logic          w_we0;
  logic          w_we1;
  logic [AW-1:0] w_waddr;

  // read side
  rd_state_e       r_state;
  rd_state_e       w_state_next;
  logic            r_rbank;
  logic            w_rbank_next;
  logic [BW-1:0]   r_rb;
  logic [BW-1:0]   w_rb_next;
  logic [SW-1:0]   r_rs;
  logic [SW-1:0]   w_rs_next;
  logic            w_pending;
  logic            w_rd_en;
  logic [AW-1:0]   w_raddr;
  logic [BITS-1:0] w_rdata0 [V];
  logic [BITS-1:0] w_rdata1 [V];
  logic [BITS-1:0] w_rdata  [V];
  logic            r_out_valid;
  logic [BITS-1:0] r_data_out [V];

  // A bank released this cycle is writable this cycle.
  assign w_release    = (r_state == RD_BURST) && (r_rb == LAST_B) && (r_rs == LAST_S);
  assign w_wr_blocked = r_full[r_wbank] && !(w_release && (r_rbank == r_wbank));
  assign w_wr_en      = in_valid && !w_wr_blocked;
  assign w_wr_last    = w_wr_en && (r_wb == LAST_B) && (r_ws == LAST_S);
  assign w_waddr      = AW'(lin_addr(32'(r_wb), 32'(r_ws), N));
  assign w_we0        = w_wr_en && !r_wbank;
  assign w_we1        = w_wr_en && r_wbank;
  assign w_pending    = r_full[r_rbank] || (w_wr_last && (r_wbank == r_rbank));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank    <= 1'b0;
      r_wb       <= '0;
      r_ws       <= '0;
      r_full     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (in_valid && w_wr_blocked) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_en) begin
        if (r_wb == LAST_B) begin
          r_wb <= '0;
          if (r_ws == LAST_S) begin
            r_ws    <= '0;
            r_wbank <= ~r_wbank;
          end else begin
            r_ws <= r_ws + 1'b1;
          end
        end else begin
          r_wb <= r_wb + 1'b1;
        end
      end
      if (w_release) begin
        r_full[r_rbank] <= 1'b0;
      end
      if (w_wr_last) begin
        r_full[r_wbank] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RD_IDLE;
      r_rbank <= 1'b0;
      r_rb    <= '0;
      r_rs    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rbank <= w_rbank_next;
      r_rb    <= w_rb_next;
      r_rs    <= w_rs_next;
    end
  end

  // IDLE reads symbol 0 on the start edge itself so output follows the
  // capturing edge by one cycle; GAP is the no-read edge between bursts.
  always_comb begin
    w_state_next = r_state;
    w_rbank_next = r_rbank;
    w_rb_next    = r_rb;
    w_rs_next    = r_rs;
    unique case (r_state)
      RD_IDLE: begin
        if (w_pending) begin
          w_state_next = RD_BURST;
          w_rs_next    = SW'(1);
        end
      end
      RD_BURST: begin
        if (r_rs == LAST_S) begin
          w_rs_next    = '0;
          w_state_next = RD_GAP;
          if (r_rb == LAST_B) begin
            w_rb_next    = '0;
            w_rbank_next = ~r_rbank;
          end else begin
            w_rb_next = r_rb + 1'b1;
          end
        end else begin
          w_rs_next = r_rs + 1'b1;
        end
      end
      RD_GAP: begin
        // rb != 0 means more blocks remain in the current bank
        if ((r_rb != '0) || w_pending) begin
          w_state_next = RD_BURST;
        end else begin
          w_state_next = RD_IDLE;
        end
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = (r_state == RD_BURST) || ((r_state == RD_IDLE) && w_pending);
    w_raddr = AW'(lin_addr(32'(r_rb), 32'(r_rs), N));
    for (int unsigned j = 0; j < V; j++) begin
      w_rdata[j] = r_rbank ? w_rdata1[j] : w_rdata0[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      for (int unsigned j = 0; j < V; j++) begin
        r_data_out[j] <= '0;
      end
    end else begin
      r_out_valid <= w_rd_en;
      if (w_rd_en) begin
        for (int unsigned j = 0; j < V; j++) begin
          r_data_out[j] <= w_rdata[j];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign overflow  = r_overflow;

  block_output_deinterleaver_bank #(
    .BITS (BITS),
    .V    (V),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_bank0 (
    .clk    (clk),
    .i_we   (w_we0),
    .i_waddr(w_waddr),
    .i_wdata(data_in),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata0)
  );

  block_output_deinterleaver_bank #(
    .BITS (BITS),
    .V    (V),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_bank1 (
    .clk    (clk),
    .i_we   (w_we1),
    .i_waddr(w_waddr),
    .i_wdata(data_in),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata1)
  );

endmodule

// File: tb/tb_block_output_deinterleaver.sv
// Scoreboard bench: drivers push expected block-ordered words, monitors pop and
// compare data, inter-burst idle count and first-word latency.
module tb_block_output_deinterleaver;

  localparam int BITS = 32;
  localparam int V    = 4;
  localparam int IIR  = 2;
  localparam int N    = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid  = 1'b0;
  logic            in_valid1 = 1'b0;
  logic [BITS-1:0] data_in   [V];
  logic [BITS-1:0] data_in1  [V];
  logic [BITS-1:0] data_out  [V];
  logic [BITS-1:0] data_out1 [V];
  logic            out_valid, out_valid1, overflow, overflow1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           gap;   // required idle cycles before this word, -1 = any
    int           lat;   // required edge number of this word, -1 = any
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int   checks = 0, failures = 0;
  bit   strict = 1'b1;
  int   idle0 = 0, idle1 = 0, seen0 = 0;

  block_output_deinterleaver #(.BITS(BITS), .IIR(IIR), .N(N), .V(V)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .overflow(overflow)
  );

  block_output_deinterleaver #(.BITS(BITS), .IIR(1), .N(4), .V(V)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .data_in(data_in1),
    .out_valid(out_valid1), .data_out(data_out1), .overflow(overflow1)
  );

  function automatic logic [31:0] tag(input int g, input int b, input int s, input int j);
    return {8'(g), 8'(b), 8'(s), 8'(j)};
  endfunction

  function automatic logic [127:0] vec(input int g, input int b, input int s);
    return {tag(g, b, s, 3), tag(g, b, s, 2), tag(g, b, s, 1), tag(g, b, s, 0)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h at cyc %0d", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q0.size() == 0) begin
        if (strict) begin
          checks++;
          failures++;
          $display("FAIL out0_unexpected act=%0h req=none at cyc %0d",
                   {data_out[3], data_out[2], data_out[1], data_out[0]}, cyc);
        end
      end else begin
        m0 = q0.pop_front();
        chk("out0_data", {data_out[3], data_out[2], data_out[1], data_out[0]}, m0.data);
        if (m0.gap >= 0) chk("out0_gap", 128'(idle0), 128'(m0.gap));
        if (m0.lat >= 0) chk("out0_latency", 128'(cyc), 128'(m0.lat));
        seen0++;
      end
      idle0 = 0;
    end else begin
      idle0++;
    end
  end

  always @(negedge clk) begin
    if (out_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out1_unexpected act=%0h req=none at cyc %0d",
                 {data_out1[3], data_out1[2], data_out1[1], data_out1[0]}, cyc);
      end else begin
        m1 = q1.pop_front();
        chk("out1_data", {data_out1[3], data_out1[2], data_out1[1], data_out1[0]}, m1.data);
        if (m1.gap >= 0) chk("out1_gap", 128'(idle1), 128'(m1.gap));
        if (m1.lat >= 0) chk("out1_latency", 128'(cyc), 128'(m1.lat));
      end
      idle1 = 0;
    end else begin
      idle1++;
    end
  end

  // every != 0: in_valid is low on each every-th cycle of the group
  task automatic send_group(input int g, input int every, input bit push,
                            input int first_gap, input bit chk_lat);
    int   k = 0;
    int   c = 0;
    int   cap;
    exp_t e;
    while (k < IIR * N) begin
      @(negedge clk);
      if (every != 0 && (c % every) == every - 1) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int j = 0; j < V; j++) data_in[j] = tag(g, k % IIR, k / IIR, j);
        k++;
      end
      c++;
    end
    cap = cyc + 1;
    if (push) begin
      for (int b = 0; b < IIR; b++) begin
        for (int s = 0; s < N; s++) begin
          e.data = vec(g, b, s);
          e.gap  = (s != 0) ? 0 : ((b == 0) ? first_gap : 1);
          e.lat  = (b == 0 && s == 0 && chk_lat) ? cap : -1;
          q0.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
    end
  endtask

  task automatic drain(input bit which, input int lim);
    int n = 0;
    while (((which ? q1.size() : q0.size()) != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "drain1_left" : "drain0_left",
        128'(which ? q1.size() : q0.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   base;
    int   n;
    int   cap1;
    exp_t e;
    for (int j = 0; j < V; j++) begin
      data_in[j]  = '0;
      data_in1[j] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data_out", {data_out[3], data_out[2], data_out[1], data_out[0]}, 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_out_valid1", 128'(out_valid1), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // single group, reader idle
    send_group(1, 0, 1'b1, -1, 1'b1);
    idle(1);
    drain(1'b0, 100);
    chk("t1_overflow", 128'(overflow), 128'(0));

    // same group with every third input cycle idle
    send_group(2, 3, 1'b1, -1, 1'b1);
    idle(1);
    drain(1'b0, 100);

    // two groups separated by exactly IIR-1 idle cycles
    send_group(3, 0, 1'b1, -1, 1'b1);
    idle(IIR - 1);
    send_group(4, 0, 1'b1, 1, 1'b0);
    idle(1);
    drain(1'b0, 150);
    chk("t3_overflow", 128'(overflow), 128'(0));

    // continuous groups: first two checked, later ones overrun the busy bank
    strict = 1'b0;
    send_group(5, 0, 1'b1, -1, 1'b1);
    send_group(6, 0, 1'b1, 1, 1'b0);
    send_group(7, 0, 1'b0, -1, 1'b0);
    send_group(8, 0, 1'b0, -1, 1'b0);
    idle(1);
    drain(1'b0, 150);
    chk("t4_overflow_set", 128'(overflow), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_overflow_cleared", 128'(overflow), 128'(0));
    chk("t4_out_valid_rst", 128'(out_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    strict = 1'b1;
    idle(5);

    // reset in the middle of block 0 readout
    base = seen0;
    send_group(9, 0, 1'b1, -1, 1'b1);
    idle(1);
    n = 0;
    while (seen0 < base + 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_readout_started", 128'(seen0 >= base + 5), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_out_valid", 128'(out_valid), 128'(0));
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(60);
    send_group(10, 0, 1'b1, -1, 1'b1);
    idle(1);
    drain(1'b0, 100);
    chk("t5_overflow", 128'(overflow), 128'(0));

    // IIR=1, N=4 passthrough instance
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      in_valid1 = 1'b1;
      for (int j = 0; j < V; j++) data_in1[j] = tag(11, 0, s, j);
    end
    cap1 = cyc + 1;
    for (int s = 0; s < 4; s++) begin
      e.data = vec(11, 0, s);
      e.gap  = (s == 0) ? -1 : 0;
      e.lat  = (s == 0) ? cap1 : -1;
      q1.push_back(e);
    end
    idle(1);
    drain(1'b1, 20);
    chk("t6_overflow1", 128'(overflow1), 128'(0));
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
